// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
// Used by mem_arbiter and arb_pick.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  // Width of a channel index; a single channel still needs a 1-bit field.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: round-robin starting after ptr_i,
// or fixed priority with channel 0 highest.
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int PRIO_MODE = PRIO_RR,
  parameter int GW        = idx_w(NCH)
) (
  input  logic [NCH-1:0] req_valid_i,
  input  logic [GW-1:0]  ptr_i,
  output logic [NCH-1:0] win_onehot_o,
  output logic [GW-1:0]  win_idx_o,
  output logic           any_o
);

  int best_d;
  int d;

  always_comb begin
    win_idx_o = '0;
    any_o     = |req_valid_i;
    best_d    = NCH;
    d         = 0;
    for (int j = 0; j < NCH; j++) begin
      if (req_valid_i[j]) begin
        // Distance from the slot just after the pointer; fixed mode uses the raw index.
        if (PRIO_MODE == PRIO_FIXED) d = j;
        else d = (j + NCH - int'(ptr_i) - 1) % NCH;
        if (d < best_d) begin
          best_d    = d;
          win_idx_o = GW'(j);
        end
      end
    end
    win_onehot_o = any_o ? (NCH'(1) << win_idx_o) : '0;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-outstanding memory port among NCH requesters.
// Optional watchdog abort is built when ARB_TIMEOUT_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int PRIO_MODE = PRIO_RR,
  parameter int TIMEOUT   = 255,
  parameter int GW        = idx_w(NCH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    req_valid,
  input  logic [NCH-1:0]    req_write,
  input  logic [NCH*AW-1:0] req_adr,
  input  logic [NCH*DW-1:0] req_wdata,
  output logic [NCH-1:0]    req_ready,
  output logic [NCH-1:0]    rsp_valid,
  output logic [DW-1:0]     rsp_rdata,
  output logic              rsp_abort,
  output logic              mem_req,
  output logic              mem_write,
  output logic [AW-1:0]     mem_adr,
  output logic [DW-1:0]     mem_wdata,
  input  logic              mem_ack,
  input  logic [DW-1:0]     mem_rdata,
  output logic              busy,
  output logic [GW-1:0]     grant_id
);

  arb_state_e     state_q, state_d;
  logic [GW-1:0]  ptr_q, ptr_d;
  logic [GW-1:0]  grant_q, grant_d;
  logic [AW-1:0]  adr_q, adr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic           write_q, write_d;
  logic [NCH-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]  rsp_rdata_q, rsp_rdata_d;

  logic [NCH-1:0] win_onehot;
  logic [GW-1:0]  win_idx;
  logic           win_any;

  arb_pick #(
    .NCH       (NCH),
    .PRIO_MODE (PRIO_MODE),
    .GW        (GW)
  ) u_pick (
    .req_valid_i  (req_valid),
    .ptr_i        (ptr_q),
    .win_onehot_o (win_onehot),
    .win_idx_o    (win_idx),
    .any_o        (win_any)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rsp_abort_q, rsp_abort_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    adr_d       = adr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    req_ready   = '0;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_abort_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (win_any) begin
          req_ready = win_onehot;
          ptr_d     = win_idx;
          grant_d   = win_idx;
          state_d   = BUSY;
          for (int j = 0; j < NCH; j++) begin
            if (win_onehot[j]) begin
              adr_d   = req_adr[j*AW +: AW];
              wdata_d = req_wdata[j*DW +: DW];
              write_d = req_write[j];
            end
          end
`ifdef ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      BUSY: begin
        // A real acknowledge always beats a watchdog expiry in the same cycle.
        if (mem_ack) begin
          rsp_valid_d = NCH'(1) << grant_q;
          rsp_rdata_d = mem_rdata;
          state_d     = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_valid_d = NCH'(1) << grant_q;
          rsp_rdata_d = '0;
          rsp_abort_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= GW'(NCH - 1);
      grant_q     <= '0;
      adr_q       <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      adr_q       <= adr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      rsp_abort_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rsp_abort_q <= rsp_abort_d;
    end
  end
  assign rsp_abort = rsp_abort_q;
`else
  assign rsp_abort = 1'b0;
`endif

  assign mem_req   = (state_q == BUSY);
  assign busy      = (state_q == BUSY);
  assign mem_write = write_q;
  assign mem_adr   = adr_q;
  assign mem_wdata = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign grant_id  = grant_q;

endmodule
